// File: rtl/heart_rate_calc.sv
`default_nettype none
// heart_rate_calc: averages the last four beat-to-beat intervals (ms) and reports BPM = 60000 / mean.
// Rev 1.0
module heart_rate_calc #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int MIN_IBI_MS = 300,
  parameter int MAX_IBI_MS = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        beat_in,
  output logic [15:0] heart_rate,
  output logic        hr_valid,
  output logic        no_pulse
);

  localparam int TICK_DIV = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]   MIN_IBI    = 16'(MIN_IBI_MS);
  localparam logic [15:0]   MAX_IBI    = 16'(MAX_IBI_MS);
  localparam logic [15:0]   DIVIDEND   = 16'd60000;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    DIVIDE     = 2'd2,
    UPDATE     = 2'd3
  } state_t;

  state_t state, state_next;

  logic               sync_1, sync_2, beat_q, beat_evt;
  logic [PW-1:0]      presc;
  logic               ms_tick;
  logic [15:0]        ibi_cnt, interval, sum;
  logic [3:0][15:0]   hist;
  logic [2:0]         fill;
  logic [15:0]        divisor, quo, rem;
  logic [3:0]         div_cnt;
  logic [16:0]        rem_shift, rem_sub;
  logic               rem_ge;
  logic               accept, timeout;

  assign beat_evt = sync_2 & ~beat_q;
  assign ms_tick  = (presc == PRESC_LAST);

  // Interval as it stands at this edge, so a beat sees the tick that lands with it.
  assign interval = (ms_tick && ibi_cnt < MAX_IBI) ? ibi_cnt + 16'd1 : ibi_cnt;
  assign sum      = interval + hist[0] + hist[1] + hist[2];

  assign rem_shift = {rem, quo[15]};
  assign rem_sub   = rem_shift - {1'b0, divisor};
  assign rem_ge    = ~rem_sub[16];

  always_ff @(posedge clk) begin
    if (!reset) state <= WAIT_FIRST;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    timeout    = 1'b0;
    case (state)
      WAIT_FIRST: begin
        if (beat_evt) begin
          accept     = 1'b1;
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (beat_evt && interval >= MIN_IBI) begin
          accept = 1'b1;
          if (fill >= 3'd3) state_next = DIVIDE;
        end else if (interval >= MAX_IBI) begin
          timeout    = 1'b1;
          state_next = WAIT_FIRST;
        end
      end
      DIVIDE: begin
        if (div_cnt == 4'd15) state_next = UPDATE;
      end
      UPDATE: begin
        state_next = MEASURE;
      end
      default: state_next = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      beat_q     <= 1'b0;
      presc      <= '0;
      ibi_cnt    <= '0;
      hist       <= '0;
      fill       <= '0;
      divisor    <= '0;
      quo        <= '0;
      rem        <= '0;
      div_cnt    <= '0;
      heart_rate <= '0;
      hr_valid   <= 1'b0;
      no_pulse   <= 1'b1;
    end else begin
      sync_1   <= beat_in;
      sync_2   <= sync_1;
      beat_q   <= sync_2;
      hr_valid <= 1'b0;

      if (accept || ms_tick) presc <= '0;
      else                   presc <= presc + 1'b1;

      ibi_cnt <= accept ? 16'd0 : interval;

      if (accept && state == WAIT_FIRST) fill <= '0;

      if (accept && state == MEASURE) begin
        hist     <= {hist[2:0], interval};
        no_pulse <= 1'b0;
        divisor  <= sum >> 2;
        rem      <= '0;
        quo      <= DIVIDEND;
        div_cnt  <= '0;
        if (fill != 3'd4) fill <= fill + 3'd1;
      end

      if (timeout) begin
        heart_rate <= '0;
        no_pulse   <= 1'b1;
        hr_valid   <= 1'b1;
        fill       <= '0;
        hist       <= '0;
      end

      // Restoring division: dividend bits shift out of quo as quotient bits shift in.
      if (state == DIVIDE) begin
        rem     <= rem_ge ? rem_sub[15:0] : rem_shift[15:0];
        quo     <= {quo[14:0], rem_ge};
        div_cnt <= div_cnt + 4'd1;
      end

      if (state == UPDATE) begin
        heart_rate <= quo;
        hr_valid   <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
